// File: rtl/detector_modo_contador.sv
// detector_modo_contador
// Watches the value stream of the mode-configurable counter and recovers its
// operating mode (up/down by 1 or 3, frozen, saturated) from the difference
// between consecutive valid samples. A mode is reported only after it has been
// seen LOCK_COUNT times in a row. Unclassifiable steps produce an `illegal`
// pulse and restart acquisition.
//
// Optional feature: define DETECTOR_ERR_COUNT_EN to build the saturating
// illegal-delta counter on `err_count`. When it is undefined `err_count` is
// tied to zero.
module detector_modo_contador #(
    parameter int LOCK_COUNT = 3,
    parameter int NBITS_CNT  = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [NBITS_CNT-1:0] count_in,
    output logic [2:0]           mode,
    output logic                 locked,
    output logic                 mode_change,
    output logic                 illegal,
    output logic [NBITS_CNT-1:0] last_delta,
    output logic [7:0]           err_count
);

    // Recovered mode codes, as presented on the `mode` output.
    typedef enum logic [2:0] {
        MODE_NONE      = 3'd0,
        MODE_UP1       = 3'd1,
        MODE_DOWN1     = 3'd2,
        MODE_UP3       = 3'd3,
        MODE_DOWN3     = 3'd4,
        MODE_FROZEN    = 3'd5,
        MODE_SATURATED = 3'd6
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Step values as seen through the wrap-around subtraction.
    localparam logic [NBITS_CNT-1:0] D_ZERO = '0;
    localparam logic [NBITS_CNT-1:0] D_UP1  = NBITS_CNT'(1);
    localparam logic [NBITS_CNT-1:0] D_UP3  = NBITS_CNT'(3);
    localparam logic [NBITS_CNT-1:0] D_DN1  = NBITS_CNT'(-1);
    localparam logic [NBITS_CNT-1:0] D_DN3  = NBITS_CNT'(-3);

    // Extremes of the counter range that mark a stuck-at-limit counter.
    localparam logic [NBITS_CNT-1:0] CNT_MIN = '0;
    localparam logic [NBITS_CNT-1:0] CNT_MAX = '1;

    localparam logic [3:0] LOCK_THR = 4'(LOCK_COUNT);
    localparam logic [3:0] RUN_MAX  = 4'hF;

    state_t                 state_reg;
    logic [NBITS_CNT-1:0]   prev_reg;
    mode_t                  cand_reg;
    logic [3:0]             run_cnt_reg;
    mode_t                  mode_reg;
    logic                   locked_reg;
    logic                   mode_change_reg;
    logic                   illegal_reg;
    logic [NBITS_CNT-1:0]   last_delta_reg;

    logic [NBITS_CNT-1:0]   delta;
    logic                   class_legal;
    mode_t                  class_mode;
    logic [3:0]             run_inc;

    // Classify the step between the incoming sample and the previous one.
    always_comb begin
        delta       = count_in - prev_reg;
        class_legal = 1'b1;
        class_mode  = MODE_NONE;
        if (delta == D_UP1) begin
            class_mode = MODE_UP1;
        end else if (delta == D_DN1) begin
            class_mode = MODE_DOWN1;
        end else if (delta == D_UP3) begin
            class_mode = MODE_UP3;
        end else if (delta == D_DN3) begin
            class_mode = MODE_DOWN3;
        end else if (delta == D_ZERO) begin
            // A counter parked at either end of its range is saturated,
            // anywhere else it is simply frozen.
            if (count_in == CNT_MIN || count_in == CNT_MAX) begin
                class_mode = MODE_SATURATED;
            end else begin
                class_mode = MODE_FROZEN;
            end
        end else begin
            class_legal = 1'b0;
        end
    end

    // Run length of the candidate class; sticks at 15 instead of wrapping.
    always_comb begin
        run_inc = (run_cnt_reg == RUN_MAX) ? RUN_MAX : run_cnt_reg + 4'd1;
    end

    // Acquisition / lock state machine with registered indications.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            prev_reg        <= '0;
            cand_reg        <= MODE_NONE;
            run_cnt_reg     <= 4'd0;
            mode_reg        <= MODE_NONE;
            locked_reg      <= 1'b0;
            mode_change_reg <= 1'b0;
            illegal_reg     <= 1'b0;
            last_delta_reg  <= '0;
        end else begin
            mode_change_reg <= 1'b0;
            illegal_reg     <= 1'b0;
            if (sample_valid) begin
                prev_reg       <= count_in;
                last_delta_reg <= delta;
                if (state_reg == ST_IDLE) begin
                    // First sample only seeds the reference value.
                    state_reg   <= ST_ACQ;
                    cand_reg    <= MODE_NONE;
                    run_cnt_reg <= 4'd0;
                    mode_reg    <= MODE_NONE;
                    locked_reg  <= 1'b0;
                end else if (!class_legal) begin
                    // Any unrecognised step throws away what was learned.
                    illegal_reg <= 1'b1;
                    state_reg   <= ST_ACQ;
                    cand_reg    <= MODE_NONE;
                    run_cnt_reg <= 4'd0;
                    mode_reg    <= MODE_NONE;
                    locked_reg  <= 1'b0;
                end else if (state_reg == ST_LOCKED) begin
                    // While locked the candidate is the reported mode.
                    if (class_mode != cand_reg) begin
                        mode_change_reg <= 1'b1;
                        state_reg       <= ST_ACQ;
                        cand_reg        <= class_mode;
                        run_cnt_reg     <= 4'd1;
                        mode_reg        <= MODE_NONE;
                        locked_reg      <= 1'b0;
                    end
                end else begin
                    if (class_mode == cand_reg) begin
                        run_cnt_reg <= run_inc;
                        if (run_inc >= LOCK_THR) begin
                            state_reg  <= ST_LOCKED;
                            mode_reg   <= cand_reg;
                            locked_reg <= 1'b1;
                        end
                    end else begin
                        cand_reg    <= class_mode;
                        run_cnt_reg <= 4'd1;
                        if (LOCK_THR == 4'd1) begin
                            state_reg  <= ST_LOCKED;
                            mode_reg   <= class_mode;
                            locked_reg <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef DETECTOR_ERR_COUNT_EN
    logic [7:0] err_count_reg;

    // Count illegal deltas, holding at 255 once full.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            err_count_reg <= 8'd0;
        end else if (sample_valid && state_reg != ST_IDLE && !class_legal
                     && err_count_reg != 8'hFF) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'd0;
`endif

    assign mode        = mode_reg;
    assign locked      = locked_reg;
    assign mode_change = mode_change_reg;
    assign illegal     = illegal_reg;
    assign last_delta  = last_delta_reg;

endmodule

// File: tb/tb_detector_modo_contador.sv
// Self-checking bench for detector_modo_contador: directed vector table,
// hand-written multi-cycle sequences (error saturation, asynchronous reset)
// and a randomized run compared against a history-based reference model.
module tb_detector_modo_contador;

    localparam int LOCK_COUNT = 3;
`ifdef DETECTOR_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [3:0] count_in;
    logic [2:0] mode;
    logic       locked;
    logic       mode_change;
    logic       illegal;
    logic [3:0] last_delta;
    logic [7:0] err_count;

    detector_modo_contador #(
        .LOCK_COUNT (LOCK_COUNT),
        .NBITS_CNT  (4)
    ) dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .mode         (mode),
        .locked       (locked),
        .mode_change  (mode_change),
        .illegal      (illegal),
        .last_delta   (last_delta),
        .err_count    (err_count)
    );

    always #5 clk_2 = ~clk_2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle and sample the outputs 1 time unit after the edge.
    task automatic apply(input bit valid, input logic [3:0] val);
        sample_valid = valid;
        count_in     = val;
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk_2);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Keeps the list of legal step classes seen since the last break
    // (reset or illegal step) and derives lock from the trailing run.
    bit         m_have_prev;
    logic [3:0] m_prev;
    int         m_hist[$];
    bit         m_locked;
    int         m_mode;
    bit         m_mc;
    bit         m_ill;
    logic [3:0] m_ld;
    int         m_err;

    function automatic int classify(input logic [3:0] d, input logic [3:0] v);
        if (d == 4'd1)  return 1;
        if (d == 4'd15) return 2;
        if (d == 4'd3)  return 3;
        if (d == 4'd13) return 4;
        if (d == 4'd0)  return (v == 4'd0 || v == 4'd15) ? 6 : 5;
        return -1;
    endfunction

    task automatic model_reset();
        m_have_prev = 1'b0;
        m_prev      = 4'd0;
        m_hist.delete();
        m_locked    = 1'b0;
        m_mode      = 0;
        m_mc        = 1'b0;
        m_ill       = 1'b0;
        m_ld        = 4'd0;
        m_err       = 0;
    endtask

    task automatic model_step(input bit valid, input logic [3:0] v);
        int c;
        int run;
        m_mc  = 1'b0;
        m_ill = 1'b0;
        if (!valid) return;
        m_ld = v - m_prev;
        if (!m_have_prev) begin
            m_have_prev = 1'b1;
            m_prev      = v;
            m_hist.delete();
            m_locked    = 1'b0;
            m_mode      = 0;
            return;
        end
        c      = classify(m_ld, v);
        m_prev = v;
        if (c < 0) begin
            m_ill = 1'b1;
            if (m_err < 255) m_err++;
            m_hist.delete();
            m_locked = 1'b0;
            m_mode   = 0;
            return;
        end
        if (m_locked && c != m_mode) m_mc = 1'b1;
        m_hist.push_back(c);
        if (m_hist.size() > 32) void'(m_hist.pop_front());
        run = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != c) break;
            run++;
        end
        m_locked = (run >= LOCK_COUNT) && !m_mc;
        m_mode   = m_locked ? c : 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_mode"},        32'(mode),        32'(m_mode));
        chk({tag, "_locked"},      32'(locked),      32'(m_locked));
        chk({tag, "_mode_change"}, 32'(mode_change), 32'(m_mc));
        chk({tag, "_illegal"},     32'(illegal),     32'(m_ill));
        chk({tag, "_last_delta"},  32'(last_delta),  32'(m_ld));
        chk({tag, "_err_count"},   32'(err_count),   ERR_EN ? 32'(m_err) : 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mode"},        32'(mode),        32'd0);
        chk({tag, "_locked"},      32'(locked),      32'd0);
        chk({tag, "_mode_change"}, 32'(mode_change), 32'd0);
        chk({tag, "_illegal"},     32'(illegal),     32'd0);
        chk({tag, "_last_delta"},  32'(last_delta),  32'd0);
        chk({tag, "_err_count"},   32'(err_count),   32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         valid;
        logic [3:0] val;
        logic [2:0] mode;
        bit         lk;
        bit         mc;
        bit         il;
        logic [3:0] ld;
        int         err;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit rst, input bit valid, input logic [3:0] val,
                        input logic [2:0] md, input bit lk, input bit mc,
                        input bit il, input logic [3:0] ld, input int err);
        vec_t v;
        v.rst = rst; v.valid = valid; v.val = val; v.mode = md; v.lk = lk;
        v.mc = mc; v.il = il; v.ld = ld; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        bit         vld;
        int         step_sel;
        logic [3:0] cur;
        logic [3:0] nv;

        reset        = 1'b1;
        sample_valid = 1'b0;
        count_in     = 4'd0;

        // rst valid val  mode lk mc il ld err
        // up by 1 from zero
        addv(1, 1,  0,  0, 0, 0, 0,  0, 0);
        addv(0, 1,  1,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  2,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  3,  1, 1, 0, 0,  1, 0);
        // down by 3 across the wrap, then frozen, idle cycle, then up1
        addv(1, 1,  2,  0, 0, 0, 0,  2, 0);
        addv(0, 1, 15,  0, 0, 0, 0, 13, 0);
        addv(0, 1, 12,  0, 0, 0, 0, 13, 0);
        addv(0, 1,  9,  4, 1, 0, 0, 13, 0);
        addv(0, 1,  9,  0, 0, 1, 0,  0, 0);
        addv(0, 1,  9,  0, 0, 0, 0,  0, 0);
        addv(0, 1,  9,  5, 1, 0, 0,  0, 0);
        addv(0, 0,  3,  5, 1, 0, 0,  0, 0);
        addv(0, 1, 10,  0, 0, 1, 0,  1, 0);
        // locked up1 at 5, then repeated 5s
        addv(1, 1,  2,  0, 0, 0, 0,  2, 0);
        addv(0, 1,  3,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  4,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  5,  1, 1, 0, 0,  1, 0);
        addv(0, 1,  5,  0, 0, 1, 0,  0, 0);
        addv(0, 1,  5,  0, 0, 0, 0,  0, 0);
        addv(0, 1,  5,  5, 1, 0, 0,  0, 0);
        addv(0, 1,  5,  5, 1, 0, 0,  0, 0);
        // locked up1 at 15, then repeated 15s
        addv(1, 1, 12,  0, 0, 0, 0, 12, 0);
        addv(0, 1, 13,  0, 0, 0, 0,  1, 0);
        addv(0, 1, 14,  0, 0, 0, 0,  1, 0);
        addv(0, 1, 15,  1, 1, 0, 0,  1, 0);
        addv(0, 1, 15,  0, 0, 1, 0,  0, 0);
        addv(0, 1, 15,  0, 0, 0, 0,  0, 0);
        addv(0, 1, 15,  6, 1, 0, 0,  0, 0);
        addv(0, 1, 15,  6, 1, 0, 0,  0, 0);
        // locked up1 at 4, then an illegal jump to 9, then reacquire
        addv(1, 1,  1,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  2,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  3,  0, 0, 0, 0,  1, 0);
        addv(0, 1,  4,  1, 1, 0, 0,  1, 0);
        addv(0, 1,  9,  0, 0, 0, 1,  5, 1);
        addv(0, 1, 10,  0, 0, 0, 0,  1, 1);
        addv(0, 1, 11,  0, 0, 0, 0,  1, 1);
        addv(0, 1, 12,  1, 1, 0, 0,  1, 1);
        // up by 3 across the wrap, then down by 3 across it
        addv(1, 1,  8,  0, 0, 0, 0,  8, 0);
        addv(0, 1, 11,  0, 0, 0, 0,  3, 0);
        addv(0, 1, 14,  0, 0, 0, 0,  3, 0);
        addv(0, 1,  1,  3, 1, 0, 0,  3, 0);
        addv(0, 1, 14,  0, 0, 1, 0, 13, 0);

        repeat (2) @(posedge clk_2);
        #1;
        reset = 1'b0;
        check_zero("reset");

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].valid, vecs[i].val);
            $display("vec %0d valid=%0d in=%0d -> mode=%0d locked=%0d mc=%0d ill=%0d ld=%0d err=%0d",
                     i, vecs[i].valid, vecs[i].val, mode, locked, mode_change,
                     illegal, last_delta, err_count);
            chk($sformatf("vec%0d_mode", i),        32'(mode),        32'(vecs[i].mode));
            chk($sformatf("vec%0d_locked", i),      32'(locked),      32'(vecs[i].lk));
            chk($sformatf("vec%0d_mode_change", i), 32'(mode_change), 32'(vecs[i].mc));
            chk($sformatf("vec%0d_illegal", i),     32'(illegal),     32'(vecs[i].il));
            chk($sformatf("vec%0d_last_delta", i),  32'(last_delta),  32'(vecs[i].ld));
            chk($sformatf("vec%0d_err_count", i),   32'(err_count),
                ERR_EN ? 32'(vecs[i].err) : 32'd0);
        end

        // 300 alternating samples 0,8: every step after the first is illegal.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, (i % 2 == 1) ? 4'd8 : 4'd0);
            chk("alt_locked", 32'(locked), 32'd0);
            chk("alt_mode_change", 32'(mode_change), 32'd0);
        end
        chk("alt_err_sat", 32'(err_count), ERR_EN ? 32'd255 : 32'd0);
        chk("alt_illegal", 32'(illegal), 32'd1);
        $display("alternating run done: err_count=%0d locked=%0d", err_count, locked);

        // Lock to up1 from 8, then reset asynchronously while locked.
        apply(1'b1, 4'd9);
        apply(1'b1, 4'd10);
        apply(1'b1, 4'd11);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        chk("pre_rst_mode", 32'(mode), 32'd1);
        sample_valid = 1'b1;
        count_in     = 4'd12;
        #1;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        $display("async reset applied between edges: mode=%0d locked=%0d err=%0d",
                 mode, locked, err_count);
        @(posedge clk_2);
        #1;
        reset = 1'b0;
        apply(1'b1, 4'd7);
        chk("post_rst_first_mode", 32'(mode), 32'd0);
        chk("post_rst_first_ld", 32'(last_delta), 32'd7);
        apply(1'b1, 4'd8);
        apply(1'b1, 4'd9);
        chk("post_rst_not_yet", 32'(locked), 32'd0);
        apply(1'b1, 4'd10);
        chk("post_rst_locked", 32'(locked), 32'd1);
        chk("post_rst_mode", 32'(mode), 32'd1);
        chk("post_rst_ld", 32'(last_delta), 32'd1);
        $display("relock after reset: mode=%0d locked=%0d", mode, locked);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        check_model("rnd_start");
        step_sel = 0;
        cur      = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                model_reset();
                check_model("rnd_rst");
                cur = 4'd0;
                continue;
            end
            vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) step_sel = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0) begin
                nv = 4'($urandom_range(0, 15));
            end else begin
                case (step_sel)
                    0:       nv = cur + 4'd1;
                    1:       nv = cur - 4'd1;
                    2:       nv = cur + 4'd3;
                    3:       nv = cur - 4'd3;
                    4:       nv = cur;
                    5:       nv = 4'd15;
                    default: nv = 4'd0;
                endcase
            end
            apply(vld, nv);
            model_step(vld, nv);
            if (vld) cur = nv;
            check_model("rnd");
        end
        $display("random run done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector_modo_contador.md
# detector_modo_contador

- Observes the 4-bit value stream of the board's mode-configurable counter and recovers its operating mode from consecutive samples.
- Modes recovered: up/down, step 1 or 3, frozen, saturated.
- Sits on the receiving side of the counter's `contador` output, clocked by `clk_2`.
- Drives mode, lock and error indications to the LCD/LED debug outputs.

## Interface
Parameters:
- `LOCK_COUNT`, default 3: consecutive identical classifications required to assert `locked`; legal range 1–15.
- `NBITS_CNT`, default 4: width of observed counter value; block is specified for 4 only.

Ports:
- `clk_2`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `sample_valid`  input  1  qualifies `count_in` for this cycle.
- `count_in`  input  4  observed counter value.
- `mode`  output  3  recovered mode: 0 NONE, 1 UP1, 2 DOWN1, 3 UP3, 4 DOWN3, 5 FROZEN, 6 SATURATED (7 unused).
- `locked`  output  1  high while in LOCKED state.
- `mode_change`  output  1  one-cycle pulse when a locked mode is abandoned for another legal class.
- `illegal`  output  1  one-cycle pulse on an unclassifiable delta.
- `last_delta`  output  4  most recent `(count_in - prev) mod 16`.
- `err_count`  output  8  saturating count of illegal deltas.

## Operation
- `prev` register holds the last valid sample; updated on every valid sample, including illegal ones.
- Delta is `count_in - prev`, 4-bit, wrap-around (0→15 gives 15).
- Classification of delta:
  - 1 → UP1; 15 → DOWN1; 3 → UP3; 13 → DOWN3.
  - 0 with `count_in` ∈ {0, 15} → SATURATED.
  - 0 otherwise → FROZEN.
  - Any other value → illegal.
- Wrap-around steps are legal: 14→1 is UP3; 1→14 is DOWN3.
- FSM states: IDLE, ACQ, LOCKED.
  - IDLE: first valid sample loads `prev` → ACQ. No classification is made; `mode` stays NONE.
  - ACQ, legal class equal to current candidate: `run_cnt`++. When `run_cnt` reaches `LOCK_COUNT` → LOCKED and `mode` = candidate.
  - ACQ, legal class different from candidate: candidate = class, `run_cnt` = 1. If `LOCK_COUNT` = 1 → LOCKED immediately.
  - LOCKED, same class: stay.
  - LOCKED, different legal class: pulse `mode_change` → ACQ, candidate = class, `run_cnt` = 1, `mode` = NONE.
  - Any state with an illegal delta: pulse `illegal` → ACQ, `run_cnt` = 0, candidate = NONE, `mode` = NONE.
- `run_cnt` is 4 bits and saturates at 15.
- No valid sample: all state holds and the pulses are low.

## Timing
- All outputs are registered and reflect the sample accepted at the previous rising edge (1-cycle latency).
- `locked` rises on the edge accepting sample number `LOCK_COUNT`+1 of a consistent run.
- `mode_change` and `illegal` are high for exactly one cycle and never both in the same cycle.
- Reset values: `mode` = 0, `locked` = 0, `mode_change` = 0, `illegal` = 0, `last_delta` = 0, `err_count` = 0; FSM in IDLE; `prev` = 0.
- Reset asserted mid-run: outputs go to reset values without waiting for a clock edge. The first valid sample after release is treated as an IDLE sample.
- `sample_valid` may be held high continuously (one sample per cycle) or pulsed sparsely; behaviour is identical.

## Configuration
- `DETECTOR_ERR_COUNT_EN` defined: `err_count` increments on each `illegal` pulse and saturates at 255.
- `DETECTOR_ERR_COUNT_EN` undefined: counter logic is removed and `err_count` is tied to 0. `illegal` pulses are unaffected.

## Test plan
- Reset, then samples 0,1,2,3: `locked`=1 and `mode`=1 after the 4th sample; `last_delta`=1.
- Samples 2,15,12,9 (DOWN3 across wrap): `mode`=4 and `locked`=1; `last_delta`=13.
- Locked UP1 at 5, then 5,5,5,5: `mode_change` pulses on the first 5; `mode`=5 FROZEN after the 4th repeat. A repeated value of 15 instead gives `mode`=6 SATURATED.
- Locked UP1 at 4, then 9: `illegal` pulses, `locked`=0, `mode`=0, `last_delta`=5, `err_count`=1 (0 with macro undefined).
- 300 alternating samples 0,8: `err_count` saturates at 255 and `locked` never asserts.
- Mid-run reset during LOCKED with `sample_valid` high: all outputs are 0 before the next edge. After release, 7,8,9,10 relocks to UP1 on the 4th sample.
